// File: rtl/load_store_unit.sv
// RV32 load/store unit: validates and aligns a datapath access, runs one memory
// handshake (req/gnt, then rvalid for loads) and returns an extended, one-cycle response.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP,
    S_RESP
  } state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        f3_legal;
  logic        aligned;
  logic        acc_err;
  logic [31:0] lane;
  logic [31:0] load_ext;

  // Accept-time checks work on the live request inputs, so errors never touch memory.
  always_comb begin
    if (req_we) f3_legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    else        f3_legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (req_funct3[1:0])
      2'b01:   aligned = !req_addr[0];
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    acc_err = !f3_legal || !aligned;
  end

  // Move the addressed lane down to bit 0, then extend according to the width code.
  always_comb begin
    lane = mem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'h0, lane[7:0]};
      3'b101:  load_ext = {16'h0, lane[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      cnt_q    <= 8'h0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: every signal gets a hold default before the case so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          err_d    = acc_err;
          cnt_d    = 8'h0;
          state_d  = acc_err ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          cnt_d   = 8'h0;
          state_d = we_q ? S_RESP : S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (mem_rvalid) begin
          rdata_d = load_ext;
          state_d = S_RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    rsp_err   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'b0000;
    case (state_q)
      S_REQ: begin
        mem_req  = 1'b1;
        mem_we   = we_q;
        mem_addr = {addr_q[31:2], 2'b00};
        case (funct3_q[1:0])
          2'b00: begin
            mem_be    = 4'b0001 << addr_q[1:0];
            mem_wdata = {4{wdata_q[7:0]}};
          end
          2'b01: begin
            mem_be    = 4'b0011 << addr_q[1:0];
            mem_wdata = {2{wdata_q[15:0]}};
          end
          default: begin
            mem_be    = 4'b1111;
            mem_wdata = wdata_q;
          end
        endcase
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases plus random
// transactions scored against a byte-lane reference model.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes, or 0 for an illegal width code.
  function automatic int size_of(input logic we, input logic [2:0] f3);
    case (f3)
      3'b000: return 1;
      3'b001: return 2;
      3'b010: return 4;
      3'b100: return we ? 0 : 1;
      3'b101: return we ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int n = size_of(we, f3);
    if (n == 0) return 1'b1;
    return (a % n) != 0;
  endfunction

  function automatic logic [3:0] model_be(input int n, input logic [31:0] a);
    int v = ((1 << n) - 1) << (a % 4);
    return v[3:0];
  endfunction

  // Lane i of the bus carries byte (i mod size) of the store data.
  function automatic logic [31:0] model_wdata(input int n, input logic [31:0] wd);
    logic [31:0] r = 0;
    for (int i = 0; i < 4; i++)
      r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int n = size_of(1'b0, f3);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 1);
    logic [31:0] v = (rd >> (8 * (a % 4))) & mask;
    if (f3[2] == 1'b0 && n < 4 && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    check({tag, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
  endtask

  // One full transaction; called and returns at a falling edge. rd_delay >= TIMEOUT means
  // the memory never answers the load.
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int gnt_delay, input int rd_delay,
                        input logic [31:0] rd, input bit stray_rvalid);
    int   n       = size_of(we, f3);
    bit   err     = model_err(we, f3, a);
    bit   tmo     = 1'b0;
    logic [31:0] exp_rd;
    check("ready_before_req", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom; req_funct3 = 3'($urandom); req_addr = $urandom;
    req_wdata = $urandom;
    if (err) begin
      check("err_no_mem_req", {31'h0, mem_req}, 32'h0);
      check("err_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("err_rsp_err", {31'h0, rsp_err}, 32'h1);
      check("err_rsp_rdata", rsp_rdata, 32'h0);
    end else begin
      for (int i = 0; i <= gnt_delay; i++) begin
        check("req_mem_req", {31'h0, mem_req}, 32'h1);
        check("req_mem_we", {31'h0, mem_we}, {31'h0, we});
        check("req_mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        check("req_mem_be", {28'h0, mem_be}, {28'h0, model_be(n, a)});
        if (we) check("req_mem_wdata", mem_wdata, model_wdata(n, wd));
        check("req_no_rsp", {31'h0, rsp_valid}, 32'h0);
        mem_gnt    = (i == gnt_delay);
        mem_rvalid = stray_rvalid;
        mem_rdata  = $urandom;
        @(negedge clk);
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      check("post_gnt_mem_req", {31'h0, mem_req}, 32'h0);
      exp_rd = 32'h0;
      if (!we) begin
        tmo = (rd_delay >= TIMEOUT);
        for (int w = 0; w < TIMEOUT; w++) begin
          check("wait_no_rsp", {31'h0, rsp_valid}, 32'h0);
          check("wait_mem_req", {31'h0, mem_req}, 32'h0);
          mem_rvalid = (w == rd_delay);
          mem_rdata  = (w == rd_delay) ? rd : $urandom;
          @(negedge clk);
          mem_rvalid = 1'b0;
          if (w == rd_delay) break;
        end
        if (!tmo) exp_rd = model_load(f3, a, rd);
      end
      check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("rsp_err", {31'h0, rsp_err}, {31'h0, tmo});
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_mem_req", {31'h0, mem_req}, 32'h0);
    end
    @(negedge clk);
    check_idle_outputs("after_rsp");
    check("ready_after_rsp", {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0;
    req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check_idle_outputs("rst");
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Directed corner cases.
    do_txn(1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234, 1'b0);
    do_txn(1'b0, 3'b100, 32'h0000_1003, 32'h0, 1, 2, 32'h80FF_1234, 1'b1);
    do_txn(1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, 0, 32'hBEEF_0000, 1'b0);
    do_txn(1'b0, 3'b001, 32'h0000_2002, 32'h0, 0, 1, 32'hBEEF_0000, 1'b0);
    do_txn(1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD, 3, 0, 32'h0, 1'b0);
    do_txn(1'b1, 3'b000, 32'h0000_0101, 32'h0000_005A, 0, 0, 32'h0, 1'b0);
    do_txn(1'b1, 3'b010, 32'h0000_0200, 32'hDEAD_BEEF, 2, 0, 32'h0, 1'b1);
    do_txn(1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 0, 32'h0, 1'b0);
    do_txn(1'b0, 3'b001, 32'h0000_0103, 32'h0, 0, 0, 32'h0, 1'b0);
    do_txn(1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 0, 32'h0, 1'b0);
    do_txn(1'b1, 3'b100, 32'h0000_0100, 32'h1, 0, 0, 32'h0, 1'b0);
    do_txn(1'b0, 3'b010, 32'h0000_0300, 32'h0, 0, TIMEOUT, 32'h0, 1'b0);
    do_txn(1'b0, 3'b010, 32'h0000_0304, 32'h0, 0, TIMEOUT - 1, 32'hCAFE_F00D, 1'b0);

    // Reset while waiting for read data: outputs clear at once, no response, late rvalid ignored.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0400;
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    check_idle_outputs("midrst");
    check("midrst_mem_addr", mem_addr, 32'h0);
    check("midrst_mem_be", {28'h0, mem_be}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_rvalid_ignored", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    check("late_rvalid_idle", {31'h0, rsp_valid}, 32'h0);
    do_txn(1'b0, 3'b010, 32'h0000_0400, 32'h0, 1, 1, 32'h0BAD_F00D, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      logic        we  = 1'($urandom);
      logic [2:0]  f3  = 3'($urandom_range(0, 7));
      logic [31:0] a   = $urandom;
      int          rdd = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, 5);
      do_txn(we, f3, a, $urandom, $urandom_range(0, 4), rdd, $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, cycles WAIT_RSP may last before an error response (range 2..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  input  1  datapath access request.
REQ-005 SHALL have port: req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_funct3  input  3  RV32 width code: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
REQ-008 SHALL have port: req_addr  input  32  byte address, ALU result.
REQ-009 SHALL have port: req_wdata  input  32  store data, rs2.
REQ-010 SHALL have port: rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: rsp_rdata  output  32  extended load result, register-file write data.
REQ-012 SHALL have port: rsp_err  output  1  misaligned, illegal funct3 or timeout.
REQ-013 SHALL have ports: mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_be out 4, mem_gnt in 1, mem_rvalid in 1, mem_rdata in 32.

Function
REQ-014 SHALL implement FSM IDLE, REQ, WAIT_RSP, RESP; req_ready=1 only in IDLE.
REQ-015 SHALL capture we/funct3/addr/wdata when req_valid&&req_ready; inputs ignored in other states.
REQ-016 SHALL flag error at accept if funct3 illegal (load: 011,110,111; store: not 000/001/010), halfword addr[0]=1, or word addr[1:0]!=0; then go IDLE->RESP with no memory access.
REQ-017 SHALL otherwise go IDLE->REQ; in REQ drive mem_req=1 with stable mem_we, mem_addr={addr[31:2],2'b00}, mem_be, mem_wdata until mem_gnt=1.
REQ-018 SHALL produce mem_be: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111; mem_wdata = store data replicated to every lane (byte x4, half x2).
REQ-019 SHALL on grant of a store go REQ->RESP; on grant of a load go REQ->WAIT_RSP.
REQ-020 SHALL in WAIT_RSP latch mem_rdata on mem_rvalid and go RESP; mem_rvalid outside WAIT_RSP ignored.
REQ-021 SHALL count WAIT_RSP cycles; on reaching TIMEOUT without rvalid, go RESP with rsp_err=1, rsp_rdata=0.
REQ-022 SHALL extract load lane by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-023 SHALL in RESP assert rsp_valid=1 for exactly one cycle, then return to IDLE; rsp_rdata=0 for stores and errors.
REQ-024 SHALL hold rsp_rdata and rsp_err stable only while rsp_valid=1; both 0 otherwise.
REQ-025 SHALL give minimum latency: store accept N, grant N+1, rsp_valid N+2; load with rvalid at N+2 gives rsp_valid N+3; error at accept gives rsp_valid N+1.
REQ-026 SHALL keep mem_req=0 in IDLE, WAIT_RSP, RESP; at most one outstanding access.

Reset
REQ-027 SHALL on rst=0 immediately enter IDLE, clear latched request, timeout counter and read data.
REQ-028 SHALL drive during reset: req_ready=1; rsp_valid, rsp_err, mem_req, mem_we=0; rsp_rdata, mem_addr, mem_wdata=0; mem_be=4'b0000.
REQ-029 SHALL abandon any in-flight access on reset mid-operation with no rsp_valid; a late mem_rvalid after release is ignored.

Verification
REQ-030 SHALL verify: LB addr 0x1003, mem_rdata 0x80FF_1234 -> mem_be 4'b1000, mem_addr 0x1000, rsp_rdata 0xFFFF_FF80.
REQ-031 SHALL verify: LHU addr 0x2002, mem_rdata 0xBEEF_0000 -> rsp_rdata 0x0000_BEEF, rsp_err 0.
REQ-032 SHALL verify: SH addr 0x0006, wdata 0x1234_ABCD, mem_gnt held low 3 cycles -> mem_req high 4 cycles, mem_be 4'b1100, mem_wdata 0xABCD_ABCD, one rsp_valid.
REQ-033 SHALL verify: LW addr 0x0102 -> no mem_req, rsp_valid next cycle with rsp_err 1, rsp_rdata 0.
REQ-034 SHALL verify: LW granted, mem_rvalid never -> rsp_err 1 after exactly TIMEOUT=16 WAIT_RSP cycles.
REQ-035 SHALL verify: rst pulled low in WAIT_RSP -> outputs at reset values at once, no rsp_valid, next request served normally.
